// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the score display: digit type and
// active-low segment patterns (bit0 = seg a ... bit6 = seg g).
package seg7_pkg;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Non-decimal codes fall through to a blank display.
    function automatic logic [6:0] seg7_lookup(input digit_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decode; digits outside the counter's
// modulus are shown blank.
module seg7_decode
    import seg7_pkg::*;
#(
    parameter int MODULUS = 10
) (
    input  logic [3:0] digit,
    output logic [6:0] pattern
);

    // Decode legal digits, blank anything the counter can never reach.
    always_comb begin
        pattern = SEG_BLANK;
        if (digit < digit_t'(MODULUS)) begin
            pattern = seg7_lookup(digit);
        end else begin
            pattern = SEG_BLANK;
        end
    end

endmodule

// File: rtl/hex_count.sv
// One decimal digit of the chainable score counter: cycle-gated increment,
// freeze via lose, combinational carry out and seven-segment display.
module hex_count
    import seg7_pkg::*;
#(
    parameter int MODULUS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cycle,
    input  logic       lose,
    input  logic       incr,
    output logic       nextIncr,
    output logic [6:0] HEX
);

    localparam digit_t LAST_DIGIT = digit_t'(MODULUS - 1);

    digit_t digit_r;
    logic   advance_s;
    logic   at_last_s;

    assign at_last_s = (digit_r == LAST_DIGIT);
    assign advance_s = cycle & ~lose & incr;

    // The carry ignores cycle so a parent sampling on the same qualified
    // edge sees it on exactly the edge where this digit wraps.
    assign nextIncr = incr & ~lose & at_last_s;

    // Digit register: async clear, modular increment on qualified edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_r <= 4'd0;
        end else if (advance_s) begin
            if (at_last_s) begin
                digit_r <= 4'd0;
            end else begin
                digit_r <= digit_r + 4'd1;
            end
        end else begin
            digit_r <= digit_r;
        end
    end

    seg7_decode #(
        .MODULUS(MODULUS)
    ) u_decode (
        .digit  (digit_r),
        .pattern(HEX)
    );

endmodule

// File: tb/tb_hex_count.sv
// Self-checking bench for hex_count: arithmetic reference model checked every
// cycle, literal spot checks, and a two-digit carry chain.
module tb_hex_count;

    localparam int MOD = 10;

    logic       clk;
    logic       reset;
    logic       cycle;
    logic       lose;
    logic       incr;
    logic       nextIncr;
    logic [6:0] HEX;

    logic       ch_reset;
    logic       ch_incr;
    logic       ch_cycle;
    logic       carry_r;
    logic       lo_next;
    logic       hi_next;
    logic [6:0] lo_hex;
    logic [6:0] hi_hex;

    int checks   = 0;
    int failures = 0;
    int m;
    bit cmp_en   = 1'b0;

    hex_count #(.MODULUS(MOD)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .cycle   (cycle),
        .lose    (lose),
        .incr    (incr),
        .nextIncr(nextIncr),
        .HEX     (HEX)
    );

    hex_count #(.MODULUS(MOD)) u_lo (
        .clk     (clk),
        .reset   (ch_reset),
        .cycle   (ch_cycle),
        .lose    (1'b0),
        .incr    (ch_incr),
        .nextIncr(lo_next),
        .HEX     (lo_hex)
    );

    hex_count #(.MODULUS(MOD)) u_hi (
        .clk     (clk),
        .reset   (ch_reset),
        .cycle   (ch_cycle),
        .lose    (1'b0),
        .incr    (carry_r),
        .nextIncr(hi_next),
        .HEX     (hi_hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Parent carry register between the two chained digits.
    always @(posedge clk or negedge ch_reset) begin
        if (!ch_reset) carry_r <= 1'b0;
        else if (ch_cycle) carry_r <= lo_next;
    end

    // Reference model: the displayed number as an integer modulo MOD.
    always @(posedge clk or negedge reset) begin
        if (!reset) m <= 0;
        else if (cycle && !lose && incr) m <= (m + 1) % MOD;
    end

    function automatic logic [6:0] exp_hex(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_hex", HEX, exp_hex(m));
            check("model_next", {6'b0, nextIncr},
                  {6'b0, (incr && !lose && (m == MOD - 1))});
        end
    end

    logic [6:0] count_seq [0:9];

    initial begin
        count_seq[0] = 7'b1111001; count_seq[1] = 7'b0100100;
        count_seq[2] = 7'b0110000; count_seq[3] = 7'b0011001;
        count_seq[4] = 7'b0010010; count_seq[5] = 7'b0000010;
        count_seq[6] = 7'b1111000; count_seq[7] = 7'b0000000;
        count_seq[8] = 7'b0010000; count_seq[9] = 7'b1000000;

        reset = 1'b0; cycle = 1'b0; lose = 1'b0; incr = 1'b0;
        ch_reset = 1'b0; ch_incr = 1'b0; ch_cycle = 1'b0;
        #1;
        check("reset_async_hex", HEX, 7'b1000000);
        cmp_en = 1'b1;

        // Reset held with random control inputs.
        for (int i = 0; i < 3; i++) begin
            cycle = 1'($urandom_range(0, 1));
            incr  = 1'($urandom_range(0, 1));
            lose  = 1'($urandom_range(0, 1));
            step();
            check("reset_hold_hex", HEX, 7'b1000000);
            check("reset_hold_next", {6'b0, nextIncr}, 7'd0);
        end

        // Count through a full wrap.
        reset = 1'b1; lose = 1'b0; cycle = 1'b1; incr = 1'b1;
        #1;
        check("pre_count_next", {6'b0, nextIncr}, 7'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("count_hex", HEX, count_seq[i]);
            check("count_next", {6'b0, nextIncr}, {6'b0, (i == 8)});
        end

        // Enable gating.
        cycle = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("gate_hold_hex", HEX, 7'b1000000);
        end
        for (int i = 0; i < 8; i++) begin
            cycle = ((i / 2) % 2) == 0;
            step();
        end
        check("gate_toggle_hex", HEX, 7'b0011001);

        // Freeze at 9.
        cycle = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("reach9_hex", HEX, 7'b0010000);
        lose = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("freeze_hex", HEX, 7'b0010000);
            check("freeze_next", {6'b0, nextIncr}, 7'd0);
        end
        lose = 1'b0;
        #1;
        check("unfreeze_next", {6'b0, nextIncr}, 7'd1);
        step();
        check("unfreeze_wrap_hex", HEX, 7'b1000000);

        // Mid-run asynchronous reset at digit 6.
        for (int i = 0; i < 6; i++) step();
        check("reach6_hex", HEX, 7'b0000010);
        reset = 1'b0;
        #1;
        check("midrun_reset_hex", HEX, 7'b1000000);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("after_reset_hex", HEX, 7'b0110000);

        // Two-digit chain: 20 increment pulses.
        ch_reset = 1'b1; ch_cycle = 1'b1;
        for (int k = 0; k < 20; k++) begin
            ch_incr = 1'b1;
            step();
            ch_incr = 1'b0;
            step();
        end
        step();
        step();
        check("chain_lo_hex", lo_hex, 7'b1000000);
        check("chain_hi_hex", hi_hex, 7'b0100100);
        check("chain_hi_next", {6'b0, hi_next}, 7'd0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hex_count.md
HEX_COUNT -- requirements
Module: hex_count

Interface
REQ-001 Parameter: MODULUS, default 10; count modulus. Legal range 2..10; the digit counts 0..MODULUS-1.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 cycle  input  1  slow-tick enable; the digit may change only on a clk edge where cycle=1.
REQ-005 lose  input  1  freeze; when 1, the digit holds and nextIncr is forced to 0.
REQ-006 incr  input  1  increment request for this digit, level-sampled.
REQ-007 nextIncr  output  1  carry to the next-higher digit, combinational.
REQ-008 HEX  output  7  active-low seven-segment pattern of the current digit; bit0=seg a … bit6=seg g.

Function
REQ-009 Internal state SHALL be a 4-bit digit register; no other state.
REQ-010 Advance condition: reset=1, cycle=1, lose=0 and incr=1 at a rising clk edge.
REQ-011 On the advance condition, the digit SHALL increment by 1. If the digit equals MODULUS-1, it SHALL wrap to 0 instead.
REQ-012 In every other case the digit SHALL hold its value. This includes incr=1 with cycle=0, and any edge with lose=1.
REQ-013 nextIncr SHALL equal incr & ~lose & (digit==MODULUS-1). It does not depend on cycle, so a parent that samples it on the same cycle-qualified edge captures the carry on the edge where this digit wraps.
REQ-014 HEX SHALL be a combinational decode of the digit:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - listed as bits 6..0
REQ-015 Digit values ≥ MODULUS cannot be reached. If decoded anyway, HEX SHALL be 1111111 (blank).
REQ-016 lose has priority over incr and cycle. reset has priority over everything.

Reset
REQ-017 While reset=0, the digit SHALL be 0 immediately, without waiting for a clk edge. HEX SHALL then read 1000000, and nextIncr follows REQ-013 with digit=0.
REQ-018 Deasserting reset mid-sequence SHALL resume counting from 0 at the next advance condition.
REQ-019 No output SHALL be X after reset, regardless of input history.

Structure
REQ-020 The seven-segment constants (SEG_0..SEG_9, SEG_BLANK) and the digit typedef (logic [3:0]) SHALL live in a shared package, seg7_pkg, reused by the display top level.
REQ-021 The decode SHALL be a separate combinational sub-module, seg7_decode, taking a 4-bit digit and producing a 7-bit pattern. hex_count SHALL instantiate it once.
REQ-022 Six hex_count instances SHALL be chainable as a decimal score counter. The parent registers each instance's nextIncr as the next instance's incr on cycle-qualified edges.

Verification
REQ-023 Reset: hold reset=0 with random cycle/incr/lose for 3 clks. Required: HEX=1000000 throughout and nextIncr=0; the digit clears asynchronously, between clk edges.
REQ-024 Count/wrap: reset=1, lose=0, cycle=1, incr=1 for 10 edges. Required: HEX steps 1,2,…,9,0; nextIncr=1 only while digit=9, then HEX returns to 1000000 after the 10th edge.
REQ-025 Enable gating: incr=1 with cycle=0 for 5 edges. Required: HEX unchanged. Then cycle toggling every 2 clks: the digit advances only on cycle=1 edges.
REQ-026 Freeze: count to 9, set lose=1, apply incr=1 and cycle=1 for 4 edges. Required: HEX stays 0010000 and nextIncr=0. Then clear lose: the next advance wraps to 0 with nextIncr=1 before the edge.
REQ-027 Mid-run reset: at digit 6, pulse reset=0 between edges. Required: HEX=1000000 immediately. After release with incr=1, three edges give 3.
REQ-028 Chain check: two instances with the parent carry register and incr pulsed 20 times. Required: the low digit reads 0 and the high digit reads 2.
